// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, start/done handshake,
// signed or unsigned multiplier per operation, result = (P >>> SHIFT) truncated with overflow flag.
module seq_booth_mult #(
  parameter int A_W   = 34,
  parameter int B_W   = 10,
  parameter int SHIFT = 9,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             b_signed,
  input  logic [A_W-1:0]   a_in,
  input  logic [B_W-1:0]   b_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  localparam int ACC_W = A_W + 1;
  localparam int Q_W   = B_W + 1;
  localparam int PW    = ACC_W + Q_W;
  localparam int CNT_W = $clog2(B_W + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [Q_W-1:0]     q_q, q_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic [A_W-1:0]     a_q, a_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   a_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   n_steps;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;
  logic [PW-OUT_W:0]  hi_bits;
  logic               accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      a_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      a_q      <= a_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    a_ext   = {a_q[A_W-1], a_q};
    n_steps = sgn_q ? CNT_W'(B_W) : CNT_W'(B_W + 1);

    unique case ({q_q[0], q1_q})
      2'b01:   acc_sum = acc_q + a_ext;
      2'b10:   acc_sum = acc_q - a_ext;
      default: acc_sum = acc_q;
    endcase

    // Signed mode runs one step fewer, so the product still sits one bit high in {acc, Q}.
    prod    = sgn_q ? ($signed({acc_q, q_q}) >>> 1) : $signed({acc_q, q_q});
    scaled  = prod >>> SHIFT;
    hi_bits = scaled[PW-1:OUT_W-1];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    a_d      = a_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    accept   = 1'b0;

    unique case (state_q)
      IDLE: accept = start;
      RUN: begin
        if (cnt_q == n_steps) begin
          state_d  = DONE;
          result_d = scaled[OUT_W-1:0];
          ovf_d    = (|hi_bits) && !(&hi_bits);
        end else begin
          acc_d = {acc_sum[ACC_W-1], acc_sum[ACC_W-1:1]};
          q_d   = {acc_sum[0], q_q[Q_W-1:1]};
          q1_d  = q_q[0];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      acc_d   = '0;
      q_d     = b_signed ? {b_in[B_W-1], b_in} : {1'b0, b_in};
      q1_d    = 1'b0;
      cnt_d   = '0;
      sgn_d   = b_signed;
      a_d     = a_in;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Scoreboard bench for seq_booth_mult: directed cases plus random operations checked
// against an integer-arithmetic model of product, shift, truncation, overflow and latency.
module tb_seq_booth_mult;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        b_signed;
  logic [33:0] a_in;
  logic [9:0]  b_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   failures;

  seq_booth_mult #(.A_W(34), .B_W(10), .SHIFT(9), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .b_signed(b_signed),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: plain integer multiply, arithmetic shift, 32-bit range test.
  function automatic exp_t model(input logic [33:0] a, input logic [9:0] b, input logic sgn, input int acc_cyc);
    exp_t   e;
    longint av, bv, p, s, lo, hi;
    av = longint'($signed(a));
    bv = sgn ? longint'($signed(b)) : longint'({1'b0, b});
    p  = av * bv;
    s  = p >>> 9;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    e.res      = s[31:0];
    e.ovf      = (s > hi) || (s < lo);
    e.done_cyc = acc_cyc + (sgn ? 10 : 11) + 1;
    return e;
  endfunction

  task automatic applyStimulus(input logic [33:0] a, input logic [9:0] b, input logic sgn, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_idle_timeout: busy=%0b, expected 0", busy);
    end
    start    = 1'b1;
    a_in     = a;
    b_in     = b;
    b_signed = sgn;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
    a_in    = ~a;
    b_in    = ~b;
    sb.push_back(model(a, b, sgn, acc_cyc));
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", 64'(result), 64'(e.res));
        checkOutput("ovf", 64'(ovf), 64'(e.ovf));
        checkOutput("latency_cycle", 64'(cyc), 64'(e.done_cyc));
      end
    end
  end

  initial begin
    int acc1, acc2, n;
    logic [33:0] ra;
    logic [9:0]  rb;
    logic        rs;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    b_signed = 1'b0;
    a_in     = '0;
    b_in     = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    applyStimulus(34'h16C16C16C, 10'h001, 1'b0, acc1);
    applyStimulus(34'd512, 10'h3FF, 1'b0, acc1);
    applyStimulus(34'd512, 10'h3FF, 1'b1, acc1);
    applyStimulus(34'h200000000, 10'h3FF, 1'b1, acc1);
    applyStimulus(34'h100000000, 10'h1FF, 1'b1, acc1);

    // Start pulses during RUN with garbage operands must be ignored.
    applyStimulus(34'h0000ABCDE, 10'h155, 1'b1, acc1);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    a_in     = 34'h3FFFFFFFF;
    b_in     = 10'h2AA;
    b_signed = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b0;

    // Back-to-back: second op accepted on the DONE cycle.
    applyStimulus(34'h000123456, 10'h07F, 1'b0, acc1);
    applyStimulus(-34'sd1024, 10'd3, 1'b1, acc2);
    checkOutput("back_to_back_accept", 64'(acc2), 64'(acc1 + 11 + 2));

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_before_reset", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(34'h0DEADBEEF, 10'h3C3, 1'b1, acc1);
    repeat (5) @(posedge clk);
    #2;
    checkOutput("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
    checkOutput("midrun_reset_done", 64'(done), 64'd0);
    checkOutput("midrun_reset_result", 64'(result), 64'd0);
    checkOutput("midrun_reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(34'h12345678, 10'h2F1, 1'b0, acc1);

    for (int i = 0; i < 40; i++) begin
      ra[31:0]  = $urandom;
      ra[33:32] = 2'($urandom_range(0, 3));
      rb        = 10'($urandom_range(0, 1023));
      rs        = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 34'h200000000;
        1: ra = 34'h1FFFFFFFF;
        2: rb = 10'h200;
        3: rb = 10'h3FF;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      applyStimulus(ra, rb, rs, acc1);
    end

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("final_drain", 64'(sb.size()), 64'd0);
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
